// File: rtl/approx_tree_err_monitor_if.sv
// Bus between the characterisation harness and the approximate-tree error monitor:
// operands and tree output in, window control and error statistics out.
interface approx_tree_err_monitor_if #(
  parameter int ACC_W = 19,
  parameter int CNT_W = 9
);
  logic [63:0]      ops;
  logic             in_valid;
  logic [10:0]      approx_y;
  logic             start;
  logic             busy;
  logic             res_valid;
  logic [ACC_W-1:0] err_sum;
  logic [10:0]      err_max;
  logic [CNT_W-1:0] err_cnt;
  logic             viol;

  modport master (
    output ops, in_valid, approx_y, start,
    input  busy, res_valid, err_sum, err_max, err_cnt, viol
  );

  modport slave (
    input  ops, in_valid, approx_y, start,
    output busy, res_valid, err_sum, err_max, err_cnt, viol
  );
endinterface

// File: rtl/approx_tree_err_monitor.sv
// Checks an 8-input approximate adder tree against an exact pipelined sum and
// collects error sum / max / nonzero count over a window of WINDOW samples.
//
// state | meaning
// IDLE  | waiting for start; last results held on the outputs
// RUN   | accepting samples and comparing tree output against the exact sum
// DONE  | window complete; res_valid pulse for this one cycle
module approx_tree_err_monitor #(
  parameter int WINDOW = 256,
  parameter int LAT    = 3,
  parameter int ACC_W  = 19,
  parameter int CNT_W  = 9
) (
  input logic clk,
  input logic rst,
  approx_tree_err_monitor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] issue_cnt, cmp_cnt;
  logic [LAT:1]     v_d;
  logic [10:0]      exact;
  logic [10:0]      err;
  logic             issue, cmp, over, last_cmp;

  assign issue    = (state == RUN) && bus.in_valid && (issue_cnt < CNT_W'(WINDOW));
  assign cmp      = v_d[LAT];
  assign over     = bus.approx_y > exact;
  assign err      = over ? 11'd0 : exact - bus.approx_y;
  assign last_cmp = cmp && (cmp_cnt == CNT_W'(WINDOW - 1));

  // Valid bit rides alongside the exact sum so it lands together with the tree output.
  generate
    if (LAT == 1) begin : g_v1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) v_d <= '0;
        else     v_d <= issue;
      end
    end else begin : g_vn
      always_ff @(posedge clk or posedge rst) begin
        if (rst) v_d <= '0;
        else     v_d <= {v_d[LAT-1:1], issue};
      end
    end
  endgenerate

  generate
    if (LAT >= 3) begin : g_staged
      logic [8:0]  s1 [4];
      logic [9:0]  s2 [2];
      logic [10:0] s3;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < 4; i++) s1[i] <= '0;
          s2[0] <= '0;
          s2[1] <= '0;
          s3    <= '0;
        end else begin
          for (int i = 0; i < 4; i++)
            s1[i] <= {1'b0, bus.ops[16*i +: 8]} + {1'b0, bus.ops[16*i+8 +: 8]};
          s2[0] <= {1'b0, s1[0]} + {1'b0, s1[1]};
          s2[1] <= {1'b0, s1[2]} + {1'b0, s1[3]};
          s3    <= {1'b0, s2[0]} + {1'b0, s2[1]};
        end
      end

      if (LAT == 3) begin : g_nopad
        assign exact = s3;
      end else begin : g_pad
        logic [10:0] pad [LAT-3];
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int i = 0; i < LAT-3; i++) pad[i] <= '0;
          end else begin
            pad[0] <= s3;
            for (int i = 1; i < LAT-3; i++) pad[i] <= pad[i-1];
          end
        end
        assign exact = pad[LAT-4];
      end
    end else begin : g_short
      // Shorter latency than the staged tree: full sum in one go, then a short delay line.
      logic [10:0] sum_c;
      logic [10:0] dly [LAT];

      always_comb begin
        sum_c = '0;
        for (int i = 0; i < 8; i++) sum_c = sum_c + 11'(bus.ops[8*i +: 8]);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++) dly[i] <= '0;
        end else begin
          dly[0] <= sum_c;
          for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
        end
      end
      assign exact = dly[LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.busy      = 1'b0;
    bus.res_valid = 1'b0;
    case (state)
      IDLE: if (bus.start) state_next = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last_cmp) state_next = DONE;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt   <= '0;
      cmp_cnt     <= '0;
      bus.err_sum <= '0;
      bus.err_max <= '0;
      bus.err_cnt <= '0;
      bus.viol    <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      issue_cnt   <= '0;
      cmp_cnt     <= '0;
      bus.err_sum <= '0;
      bus.err_max <= '0;
      bus.err_cnt <= '0;
      bus.viol    <= 1'b0;
    end else begin
      if (issue) issue_cnt <= issue_cnt + CNT_W'(1);
      if (cmp) begin
        cmp_cnt     <= cmp_cnt + CNT_W'(1);
        bus.err_sum <= bus.err_sum + ACC_W'(err);
        if (err > bus.err_max) bus.err_max <= err;
        if (err != 11'd0)      bus.err_cnt <= bus.err_cnt + CNT_W'(1);
        if (over)              bus.viol    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_approx_tree_err_monitor.sv
// Directed bench for approx_tree_err_monitor: a WINDOW=4 and a WINDOW=3 instance
// share operands and a 3-cycle tree-output delay model; each has its own start.
module tb_approx_tree_err_monitor;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ops;
  logic        in_valid;
  logic [10:0] ap_in;
  logic [10:0] ap_p [3];
  logic        start4, start3;
  int          checks = 0;
  int          errors = 0;
  int          rv4_cnt = 0;
  int          rv3_cnt = 0;

  always #5 clk = ~clk;

  approx_tree_err_monitor_if #(.ACC_W(19), .CNT_W(9)) bus4 ();
  approx_tree_err_monitor_if #(.ACC_W(19), .CNT_W(9)) bus3 ();

  assign bus4.ops      = ops;
  assign bus4.in_valid = in_valid;
  assign bus4.approx_y = ap_p[2];
  assign bus4.start    = start4;
  assign bus3.ops      = ops;
  assign bus3.in_valid = in_valid;
  assign bus3.approx_y = ap_p[2];
  assign bus3.start    = start3;

  approx_tree_err_monitor #(.WINDOW(4), .LAT(3), .ACC_W(19), .CNT_W(9)) u4 (
    .clk(clk), .rst(rst), .bus(bus4));
  approx_tree_err_monitor #(.WINDOW(3), .LAT(3), .ACC_W(19), .CNT_W(9)) u3 (
    .clk(clk), .rst(rst), .bus(bus3));

  // Tree model: the hand-computed approx value appears 3 registers after its operands.
  always @(posedge clk) begin
    ap_p[0] <= ap_in;
    ap_p[1] <= ap_p[0];
    ap_p[2] <= ap_p[1];
  end

  always @(negedge clk) begin
    if (bus4.res_valid === 1'b1) rv4_cnt++;
    if (bus3.res_valid === 1'b1) rv3_cnt++;
  end

  task automatic cyc(input logic [63:0] o, input logic v, input logic [10:0] a);
    ops = o; in_valid = v; ap_in = a;
    @(negedge clk);
  endtask

  task automatic wait_res4(input int t0, output int t);
    t = t0;
    while (bus4.res_valid !== 1'b1 && t < 40) begin
      cyc(64'd0, 1'b0, 11'd0);
      t++;
    end
    if (bus4.res_valid !== 1'b1) t = -1;
  endtask

  task automatic wait_res3(input int t0, output int t);
    t = t0;
    while (bus3.res_valid !== 1'b1 && t < 40) begin
      cyc(64'd0, 1'b0, 11'd0);
      t++;
    end
    if (bus3.res_valid !== 1'b1) t = -1;
  endtask

  task automatic start_w4();
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start4 = 1'b0; start3 = 1'b0;
    ops = '0; in_valid = 1'b0; ap_in = '0;
    repeat (4) @(negedge clk);
    checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus4.busy); end
    checks++; if (bus4.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", bus4.res_valid); end
    checks++; if (bus4.err_sum !== 19'd0) begin errors++; $display("FAIL reset_err_sum: got %0d expected 0", bus4.err_sum); end
    checks++; if (bus4.err_max !== 11'd0) begin errors++; $display("FAIL reset_err_max: got %0d expected 0", bus4.err_max); end
    checks++; if (bus4.err_cnt !== 9'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", bus4.err_cnt); end
    checks++; if (bus4.viol !== 1'b0) begin errors++; $display("FAIL reset_viol: got %b expected 0", bus4.viol); end
    checks++; if (bus3.err_sum !== 19'd0 || bus3.busy !== 1'b0) begin errors++; $display("FAIL reset_w3: got sum %0d busy %b expected 0 0", bus3.err_sum, bus3.busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_window_basic();
    int t, rv0;
    start_w4();
    checks++; if (bus4.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", bus4.busy); end
    rv0 = rv4_cnt;
    repeat (4) cyc({8{8'h07}}, 1'b1, 11'd7);
    wait_res4(4, t);
    checks++; if (t != 7) begin errors++; $display("FAIL basic_latency: got %0d expected 7", t); end
    checks++; if (bus4.err_sum !== 19'd196) begin errors++; $display("FAIL basic_err_sum: got %0d expected 196", bus4.err_sum); end
    checks++; if (bus4.err_max !== 11'd49) begin errors++; $display("FAIL basic_err_max: got %0d expected 49", bus4.err_max); end
    checks++; if (bus4.err_cnt !== 9'd4) begin errors++; $display("FAIL basic_err_cnt: got %0d expected 4", bus4.err_cnt); end
    checks++; if (bus4.viol !== 1'b0 || bus4.busy !== 1'b0) begin errors++; $display("FAIL basic_viol_busy: got %b %b expected 0 0", bus4.viol, bus4.busy); end
    cyc(64'd0, 1'b0, 11'd0);
    checks++; if (bus4.res_valid !== 1'b0 || bus4.err_sum !== 19'd196) begin errors++; $display("FAIL basic_hold: got rv %b sum %0d expected 0 196", bus4.res_valid, bus4.err_sum); end
    repeat (3) cyc(64'd0, 1'b0, 11'd0);
    checks++; if (rv4_cnt - rv0 != 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", rv4_cnt - rv0); end
  endtask

  task automatic test_window3();
    int t;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc(64'h0101, 1'b1, 11'd1);
    cyc(64'h0201, 1'b1, 11'd3);
    cyc({8{8'h07}}, 1'b1, 11'd7);
    wait_res3(3, t);
    checks++; if (t != 6) begin errors++; $display("FAIL w3_latency: got %0d expected 6", t); end
    checks++; if (bus3.err_sum !== 19'd50) begin errors++; $display("FAIL w3_err_sum: got %0d expected 50", bus3.err_sum); end
    checks++; if (bus3.err_max !== 11'd49) begin errors++; $display("FAIL w3_err_max: got %0d expected 49", bus3.err_max); end
    checks++; if (bus3.err_cnt !== 9'd2) begin errors++; $display("FAIL w3_err_cnt: got %0d expected 2", bus3.err_cnt); end
    checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL w3_other_idle: got %b expected 0", bus4.busy); end
    repeat (2) cyc(64'd0, 1'b0, 11'd0);
  endtask

  task automatic test_viol();
    int t;
    start_w4();
    checks++; if (bus4.err_sum !== 19'd0) begin errors++; $display("FAIL viol_start_clear: got %0d expected 0", bus4.err_sum); end
    repeat (4) cyc({8{8'h08}}, 1'b1, 11'd100);
    wait_res4(4, t);
    checks++; if (t != 7) begin errors++; $display("FAIL viol_latency: got %0d expected 7", t); end
    checks++; if (bus4.viol !== 1'b1) begin errors++; $display("FAIL viol_flag: got %b expected 1", bus4.viol); end
    checks++; if (bus4.err_sum !== 19'd0 || bus4.err_cnt !== 9'd0 || bus4.err_max !== 11'd0) begin errors++; $display("FAIL viol_stats: got %0d %0d %0d expected 0 0 0", bus4.err_sum, bus4.err_max, bus4.err_cnt); end
    cyc(64'd0, 1'b0, 11'd0);
    checks++; if (bus4.viol !== 1'b1) begin errors++; $display("FAIL viol_sticky: got %b expected 1", bus4.viol); end
  endtask

  task automatic test_exact_match();
    int t;
    start_w4();
    checks++; if (bus4.viol !== 1'b0) begin errors++; $display("FAIL match_viol_clear: got %b expected 0", bus4.viol); end
    repeat (4) cyc({8{8'h08}}, 1'b1, 11'd64);
    wait_res4(4, t);
    checks++; if (t != 7) begin errors++; $display("FAIL match_latency: got %0d expected 7", t); end
    checks++; if (bus4.err_sum !== 19'd0 || bus4.err_max !== 11'd0 || bus4.err_cnt !== 9'd0) begin errors++; $display("FAIL match_stats: got %0d %0d %0d expected 0 0 0", bus4.err_sum, bus4.err_max, bus4.err_cnt); end
    checks++; if (bus4.viol !== 1'b0) begin errors++; $display("FAIL match_viol: got %b expected 0", bus4.viol); end
    cyc(64'd0, 1'b0, 11'd0);
  endtask

  task automatic test_gaps();
    int t, rv0;
    start_w4();
    rv0 = rv4_cnt;
    cyc({8{8'h07}}, 1'b1, 11'd7);
    cyc({8{8'hAA}}, 1'b0, 11'd0);
    start4 = 1'b1;
    cyc({8{8'hAA}}, 1'b0, 11'd0);
    start4 = 1'b0;
    cyc(64'h0101, 1'b1, 11'd1);
    cyc({8{8'h08}}, 1'b1, 11'd64);
    cyc(64'd0, 1'b0, 11'd0);
    cyc({8{8'h03}}, 1'b1, 11'd20);
    cyc({8{8'hFF}}, 1'b1, 11'd0);
    checks++; if (bus4.busy !== 1'b1) begin errors++; $display("FAIL gaps_busy: got %b expected 1", bus4.busy); end
    wait_res4(8, t);
    checks++; if (t != 10) begin errors++; $display("FAIL gaps_latency: got %0d expected 10", t); end
    checks++; if (bus4.err_sum !== 19'd54) begin errors++; $display("FAIL gaps_err_sum: got %0d expected 54", bus4.err_sum); end
    checks++; if (bus4.err_max !== 11'd49 || bus4.err_cnt !== 9'd3) begin errors++; $display("FAIL gaps_max_cnt: got %0d %0d expected 49 3", bus4.err_max, bus4.err_cnt); end
    repeat (4) cyc(64'd0, 1'b0, 11'd0);
    checks++; if (bus4.err_sum !== 19'd54) begin errors++; $display("FAIL gaps_hold: got %0d expected 54", bus4.err_sum); end
    checks++; if (rv4_cnt - rv0 != 1) begin errors++; $display("FAIL gaps_pulses: got %0d expected 1", rv4_cnt - rv0); end
  endtask

  task automatic test_reset_mid();
    int t, rv0;
    start_w4();
    cyc({8{8'h07}}, 1'b1, 11'd7);
    cyc({8{8'h08}}, 1'b1, 11'd100);
    repeat (3) cyc(64'd0, 1'b0, 11'd0);
    checks++; if (bus4.err_sum !== 19'd49 || bus4.viol !== 1'b1) begin errors++; $display("FAIL rmid_pre: got sum %0d viol %b expected 49 1", bus4.err_sum, bus4.viol); end
    rst = 1'b1;
    #1;
    checks++; if (bus4.err_sum !== 19'd0 || bus4.err_max !== 11'd0 || bus4.err_cnt !== 9'd0) begin errors++; $display("FAIL rmid_stats: got %0d %0d %0d expected 0 0 0", bus4.err_sum, bus4.err_max, bus4.err_cnt); end
    checks++; if (bus4.viol !== 1'b0 || bus4.busy !== 1'b0 || bus4.res_valid !== 1'b0) begin errors++; $display("FAIL rmid_flags: got %b %b %b expected 0 0 0", bus4.viol, bus4.busy, bus4.res_valid); end
    @(negedge clk);
    rst = 1'b0;
    rv0 = rv4_cnt;
    repeat (8) cyc(64'd0, 1'b0, 11'd0);
    checks++; if (rv4_cnt != rv0 || bus4.busy !== 1'b0) begin errors++; $display("FAIL rmid_no_result: got pulses %0d busy %b expected 0 0", rv4_cnt - rv0, bus4.busy); end
    start_w4();
    repeat (4) cyc({8{8'h07}}, 1'b1, 11'd7);
    wait_res4(4, t);
    checks++; if (t != 7) begin errors++; $display("FAIL rmid_latency: got %0d expected 7", t); end
    checks++; if (bus4.err_sum !== 19'd196 || bus4.err_max !== 11'd49 || bus4.err_cnt !== 9'd4) begin errors++; $display("FAIL rmid_stats_after: got %0d %0d %0d expected 196 49 4", bus4.err_sum, bus4.err_max, bus4.err_cnt); end
    cyc(64'd0, 1'b0, 11'd0);
  endtask

  initial begin
    test_reset();
    test_window_basic();
    test_window3();
    test_viol();
    test_exact_match();
    test_gaps();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/approx_tree_err_monitor.md
Name: approx_tree_err_monitor

Overview:
- Consumer-side checker for the 8-input, 3-stage pipelined approximate (OR-low-bits) adder tree.
- Takes the same eight operands the tree receives and the tree's 11-bit output. Internally computes the exact sum, pipelined to the tree latency.
- Accumulates error statistics (sum, max and count of nonzero errors) over a programmable window of samples, then reports them with a one-cycle result pulse.
- Used in silicon/FPGA characterisation of approximate-arithmetic accuracy.

Parameters:
WINDOW, 256, number of compared samples per measurement window (>=1)
LAT, 3, tree latency in cycles from operand sample edge to valid y (>=1)
ACC_W, 19, width of err_sum accumulator (11 + log2(WINDOW))
CNT_W, 9, width of sample/error counters (holds WINDOW)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
ops  in  64  operands a..h packed, a=ops[7:0] ... h=ops[63:56], same values driven to tree
in_valid  in  1  ops valid this cycle (same cycle tree samples them)
approx_y  in  11  tree output y
start  in  1  begin a new window (pulse)
busy  out  1  high in RUN
res_valid  out  1  one-cycle pulse when window results are final
err_sum  out  ACC_W  sum of (exact - approx) over window
err_max  out  11  largest single error in window
err_cnt  out  CNT_W  number of samples with nonzero error
viol  out  1  sticky: some sample had approx_y > exact

Behaviour:
- Reset: all outputs 0. State IDLE. Issue/compare counters, exact pipeline and valid shift register cleared. Reset mid-window abandons the window; no res_valid.
- States: IDLE -> RUN on start. RUN -> DONE when cmp_cnt reaches WINDOW. DONE -> IDLE unconditionally next cycle.
- start in IDLE:
  - clears err_sum, err_max, err_cnt, viol, issue_cnt and cmp_cnt;
  - res_valid not asserted.
  - start in RUN or DONE is ignored.
- Issue: in RUN, in_valid accepted only while issue_cnt < WINDOW; each acceptance increments issue_cnt.
  - in_valid in IDLE/DONE, or beyond WINDOW, does not enter the valid pipeline.
- Exact path:
  - Stage 1 forms four 9-bit pair sums; stage 2 forms two 10-bit sums; stage 3 forms the 11-bit total.
  - Widths never overflow.
  - Valid bit travels in a LAT-deep shift register alongside. For LAT != 3, the exact total is delayed or advanced by padding/bypass registers so that it lands with v_d[LAT].
- Compare cycle, when v_d[LAT]=1:
  - err = exact - approx_y, 11-bit unsigned.
  - If approx_y > exact: set viol and use err = 0.
  - err_sum += err.
  - err_max = max(err_max, err).
  - err_cnt += (err != 0).
  - cmp_cnt += 1.
- Window end: the compare that makes cmp_cnt == WINDOW updates the statistics, and state enters DONE.
  - res_valid = 1 for exactly that DONE cycle.
  - Outputs hold their values until the next start.
- busy = (state == RUN). It deasserts in the DONE cycle.
- Pipeline drain: in-flight samples issued before reset are discarded by the reset clear. Issue count equals compare count by construction, so there are no extra compares.
- Gaps in in_valid are allowed; statistics only advance on compare cycles.
- Error is nonnegative for a correct tree, since OR <= add in the low bits. viol indicates a faulty tree or misalignment.
- Saturation: err_sum must not overflow with defaults (max error < 2^11, window 256).

Test Plan:
- WINDOW=4, all operands 0x07 for 4 consecutive cycles, approx_y from reference tree (7) -> exact 56, err 49 each; res_valid pulse 3+4 cycles after first issue; err_sum=196, err_max=49, err_cnt=4, viol=0.
- WINDOW=4, all operands 0x08 -> approx=exact=64; err_sum=0, err_max=0, err_cnt=0.
- WINDOW=3, samples {a=1,b=1}, {a=1,b=2}, {all 0x07}, others 0 -> errs 1, 0, 49; err_sum=50, err_max=49, err_cnt=2.
- Force approx_y=100 with all operands 0x08 (exact 64) -> viol=1 stays set, err counted 0, res_valid still fires after WINDOW compares.
- in_valid gaps (1 0 0 1 1 0 1) with WINDOW=4 -> exactly 4 compares, res_valid once; a fifth in_valid in the same window is ignored; start during RUN is ignored.
- Assert rst after 2 of 4 samples -> all outputs 0, no res_valid; a new start then completes a normal 4-sample window with correct totals.
